// File: rtl/iterative_multiplier_if.sv
// iterative_multiplier_if: start/done handshake, operands and product of the multi-cycle multiplier
interface iterative_multiplier_if #(parameter int WIDTH = 32);
  logic start, is_signed, flush, ready, busy, done;
  logic [WIDTH-1:0] a, b;
  logic [2*WIDTH-1:0] result;
  modport master(output start, is_signed, flush, a, b, input ready, busy, done, result);
  modport slave(input start, is_signed, flush, a, b, output ready, busy, done, result);
endinterface

// File: rtl/iterative_multiplier.sv
// iterative_multiplier: shift-add multiplier retiring BITS_PER_CYCLE multiplier bits per clock,
// signed or unsigned per operation, with a start/done handshake and flush.
module iterative_multiplier #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input logic clk,
  input logic reset,
  iterative_multiplier_if.slave io
);
  localparam int N  = WIDTH / BITS_PER_CYCLE;
  localparam int CW = $clog2(N + 1);
  localparam int P  = 2 * WIDTH;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [P-1:0] acc_q, acc_d, result_q, result_d, part, sum;
  logic [WIDTH:0] ma_q, ma_d, mb_q, mb_d, ext_a, ext_b;
  logic sign_q, sign_d, accept, last;
  always_comb begin
    ext_a = {io.is_signed & io.a[WIDTH-1], io.a};
    ext_b = {io.is_signed & io.b[WIDTH-1], io.b};
    part = (P'(ma_q) * P'(mb_q[BITS_PER_CYCLE-1:0])) << (cnt_q * BITS_PER_CYCLE);
    sum = acc_q + part;
    last = cnt_q == CW'(N - 1);
    accept = state_q != RUN && io.start && !io.flush;
    state_d = state_q;
    cnt_d = cnt_q;
    acc_d = acc_q;
    ma_d = ma_q;
    mb_d = mb_q;
    sign_d = sign_q;
    result_d = result_q;
    if (io.flush && state_q != IDLE) state_d = IDLE;
    else if (accept) begin
      state_d = RUN;
      cnt_d = '0;
      acc_d = '0;
      ma_d = ext_a[WIDTH] ? -ext_a : ext_a;
      mb_d = ext_b[WIDTH] ? -ext_b : ext_b;
      sign_d = io.is_signed & (io.a[WIDTH-1] ^ io.b[WIDTH-1]);
    end else if (state_q == RUN) begin
      acc_d = sum;
      cnt_d = cnt_q + CW'(1);
      mb_d = mb_q >> BITS_PER_CYCLE;
      // the product is published on the final step so it is valid during DONE
      if (last) begin
        state_d = DONE;
        result_d = sign_q ? -sum : sum;
      end
    end else if (state_q == DONE) state_d = IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      acc_q <= '0;
      ma_q <= '0;
      mb_q <= '0;
      sign_q <= 1'b0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      ma_q <= ma_d;
      mb_q <= mb_d;
      sign_q <= sign_d;
      result_q <= result_d;
    end
  end
  assign io.ready = state_q != RUN;
  assign io.busy = state_q == RUN;
  assign io.done = state_q == DONE;
  assign io.result = result_q;
endmodule

// File: tb/tb_iterative_multiplier.sv
// tb_iterative_multiplier: directed and random checks of the WIDTH=8 multiplier at 1 and 4 bits per cycle
module tb_iterative_multiplier;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, is_signed = 1'b0, flush = 1'b0, sel = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic ready, busy, done;
  logic [15:0] result;
  int checks = 0, errors = 0;
  iterative_multiplier_if #(.WIDTH(8)) i1();
  iterative_multiplier_if #(.WIDTH(8)) i4();
  assign i1.start = start & ~sel;
  assign i1.flush = flush & ~sel;
  assign i1.is_signed = is_signed;
  assign i1.a = a;
  assign i1.b = b;
  assign i4.start = start & sel;
  assign i4.flush = flush & sel;
  assign i4.is_signed = is_signed;
  assign i4.a = a;
  assign i4.b = b;
  assign ready = sel ? i4.ready : i1.ready;
  assign busy = sel ? i4.busy : i1.busy;
  assign done = sel ? i4.done : i1.done;
  assign result = sel ? i4.result : i1.result;
  iterative_multiplier #(.WIDTH(8), .BITS_PER_CYCLE(1)) dut1(.clk(clk), .reset(reset), .io(i1));
  iterative_multiplier #(.WIDTH(8), .BITS_PER_CYCLE(4)) dut4(.clk(clk), .reset(reset), .io(i4));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [15:0] ref_mul(input logic [7:0] x, input logic [7:0] y, input logic s);
    logic signed [15:0] p;
    p = $signed(x) * $signed(y);
    return s ? p : {8'b0, x} * {8'b0, y};
  endfunction
  task automatic op(input string tag, input logic [7:0] x, input logic [7:0] y, input logic s,
                    input logic [15:0] e);
    int n = sel ? 2 : 8;
    int bad = 0;
    a = x;
    b = y;
    is_signed = s;
    start = 1'b1;
    tick();
    start = 1'b0;
    a = 8'($urandom);
    b = 8'($urandom);
    is_signed = 1'($urandom);
    for (int c = 1; c <= n; c++) begin
      if (busy !== 1'b1 || done !== 1'b0 || ready !== 1'b0) bad++;
      tick();
    end
    chk({tag, " busy"}, 16'(bad), 16'd0);
    chk({tag, " done"}, 16'({ready, busy, done}), 16'b101);
    chk({tag, " res"}, result, e);
    tick();
    chk({tag, " idle"}, 16'({ready, busy, done}), 16'b100);
  endtask
  initial begin
    int nd, bad;
    logic [7:0] x, y;
    logic s;
    tick();
    tick();
    reset = 1'b0;
    chk("rst flags", 16'({ready, busy, done}), 16'b100);
    chk("rst res", result, 16'h0000);
    op("u13x11", 8'd13, 8'd11, 1'b0, 16'h008F);
    op("s-3x5", 8'hFD, 8'd5, 1'b1, 16'hFFF1);
    op("s-128sq", 8'h80, 8'h80, 1'b1, 16'h4000);
    op("u255sq", 8'hFF, 8'hFF, 1'b0, 16'hFE01);
    // start while busy is ignored
    a = 8'd6; b = 8'd7; is_signed = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    nd = 0;
    for (int c = 1; c <= 12; c++) begin
      if (c == 2) begin a = 8'd9; b = 8'd9; start = 1'b1; end
      if (c == 3) start = 1'b0;
      if (done) begin
        nd++;
        chk("busy start res", result, 16'h002A);
      end
      tick();
    end
    chk("busy start ndone", 16'(nd), 16'd1);
    // back-to-back with start held through DONE
    a = 8'd13; b = 8'd11; start = 1'b1;
    tick();
    a = 8'd2; b = 8'd3;
    for (int c = 1; c <= 8; c++) tick();
    chk("b2b first done", 16'({ready, busy, done}), 16'b101);
    chk("b2b first res", result, 16'h008F);
    tick();
    start = 1'b0;
    bad = 0;
    for (int c = 10; c <= 17; c++) begin
      if (result !== 16'h008F || done !== 1'b0) bad++;
      tick();
    end
    chk("b2b hold", 16'(bad), 16'd0);
    chk("b2b second done", 16'(done), 16'd1);
    chk("b2b second res", result, 16'h0006);
    tick();
    // flush mid-operation
    a = 8'd5; b = 8'd5; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush flags", 16'({ready, busy, done}), 16'b100);
    nd = 0;
    for (int c = 0; c < 12; c++) begin
      nd += int'(done);
      tick();
    end
    chk("flush ndone", 16'(nd), 16'd0);
    chk("flush res", result, 16'h0006);
    flush = 1'b1; start = 1'b1; a = 8'd3; b = 8'd3;
    tick();
    flush = 1'b0; start = 1'b0;
    chk("flush+start idle", 16'({ready, busy, done}), 16'b100);
    // reset mid-operation
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid rst flags", 16'({ready, busy, done}), 16'b100);
    chk("mid rst res", result, 16'h0000);
    sel = 1'b1;
    op("r4 s7x-9", 8'd7, 8'hF7, 1'b1, 16'hFFC1);
    for (int m = 0; m < 2; m++) begin
      sel = 1'(m);
      for (int i = 0; i < 12; i++) begin
        x = 8'($urandom);
        y = 8'($urandom);
        s = 1'($urandom);
        op("rnd", x, y, s, ref_mul(x, y, s));
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
